// File: rtl/wb_stage_mc.sv
// Writeback stage: picks the register-file write source, aligns and
// extends sub-word loads, and stalls upstream while a load response is
// outstanding.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | ready for a new instruction; non-loads and hit loads retire
// WAIT_MEM | load accepted without data; waiting for dmem_rvalid/timeout
module wb_stage_mc #(
    parameter int XLEN        = 32,
    parameter int RF_AW       = 5,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       wb_src,
    input  logic [RF_AW-1:0] rd,
    input  logic [XLEN-1:0]  result,
    input  logic [XLEN-1:0]  csr_dataout,
    input  logic [XLEN-1:0]  pc,
    input  logic [1:0]       ld_size,
    input  logic             ld_unsigned,
    input  logic [2:0]       ld_off,
    input  logic             dmem_rvalid,
    input  logic [XLEN-1:0]  dmem_rdata,
    output logic             rf_wen,
    output logic [RF_AW-1:0] rf_waddr,
    output logic [XLEN-1:0]  rf_wdata,
    output logic             busy,
    output logic [RF_AW-1:0] busy_rd,
    output logic             load_err
);

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_MEM = 1'b1
    } state_t;

    localparam int CW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [CW-1:0] TO_LAST = CW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);
    // On a 32-bit datapath the top offset bit would shift past the word.
    localparam logic [2:0] OFF_MASK = (XLEN == 64) ? 3'b111 : 3'b011;

    state_t            state;
    logic [CW-1:0]     to_cnt;
    logic [RF_AW-1:0]  l_rd;
    logic [1:0]        l_size;
    logic              l_uns;
    logic [2:0]        l_off;
    logic              l_wen;
    logic              eff_wen;
    logic [XLEN-1:0]   src_val;
    logic [XLEN-1:0]   held_ld_val;

    // Shift the addressed lane down, keep 8/16/32/XLEN bits, then extend.
    function automatic logic [XLEN-1:0] extend_load(
        input logic [XLEN-1:0] raw,
        input logic [1:0]      sz,
        input logic            uns,
        input logic [2:0]      off
    );
        logic [XLEN-1:0] lane;
        logic [XLEN-1:0] mask;
        logic [2:0]      off_m;
        logic            sbit;
        off_m = off & OFF_MASK;
        lane  = raw >> {off_m, 3'b000};
        case (sz)
            2'd0: begin
                mask = XLEN'(8'hFF);
                sbit = lane[7];
            end
            2'd1: begin
                mask = XLEN'(16'hFFFF);
                sbit = lane[15];
            end
            2'd2: begin
                mask = XLEN'(32'hFFFF_FFFF);
                sbit = lane[31];
            end
            default: begin
                mask = '1;
                sbit = lane[XLEN-1];
            end
        endcase
        return (lane & mask) | ((sbit && !uns) ? ~mask : '0);
    endfunction

    assign eff_wen  = wb_src[2] && (rd != '0);
    assign in_ready = (state == IDLE);
    assign busy     = (state == WAIT_MEM);

    // Write data for an instruction retiring straight from IDLE.
    always_comb begin
        src_val = '0;
        case (wb_src[1:0])
            2'd0:    src_val = extend_load(dmem_rdata, ld_size, ld_unsigned, ld_off);
            2'd1:    src_val = result;
            2'd2:    src_val = csr_dataout;
            default: src_val = pc + XLEN'(4);
        endcase
    end

    // Write data for a stalled load, using the load shape captured at accept.
    always_comb begin
        held_ld_val = extend_load(dmem_rdata, l_size, l_uns, l_off);
    end

    // Control FSM with registered register-file and hazard outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            to_cnt   <= '0;
            l_rd     <= '0;
            l_size   <= '0;
            l_uns    <= 1'b0;
            l_off    <= '0;
            l_wen    <= 1'b0;
            rf_wen   <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
            busy_rd  <= '0;
            load_err <= 1'b0;
        end else begin
            rf_wen   <= 1'b0;
            load_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if ((wb_src[1:0] != 2'd0) || dmem_rvalid) begin
                            rf_wen   <= eff_wen;
                            rf_waddr <= rd;
                            rf_wdata <= src_val;
                        end else begin
                            state   <= WAIT_MEM;
                            to_cnt  <= '0;
                            l_rd    <= rd;
                            l_size  <= ld_size;
                            l_uns   <= ld_unsigned;
                            l_off   <= ld_off;
                            l_wen   <= eff_wen;
                            busy_rd <= eff_wen ? rd : '0;
                        end
                    end
                end
                WAIT_MEM: begin
                    if (dmem_rvalid) begin
                        rf_wen   <= l_wen;
                        rf_waddr <= l_rd;
                        rf_wdata <= held_ld_val;
                        state    <= IDLE;
                        to_cnt   <= '0;
                        busy_rd  <= '0;
                    end else if ((MEM_TIMEOUT != 0) && (to_cnt == TO_LAST)) begin
                        load_err <= 1'b1;
                        state    <= IDLE;
                        to_cnt   <= '0;
                        busy_rd  <= '0;
                    end else begin
                        to_cnt <= to_cnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_stage_mc.sv
// Self-checking bench for wb_stage_mc: directed scenarios with literal
// expectations plus randomized traffic against a behavioural model.
module tb_wb_stage_mc;

    localparam int XLEN = 32;
    localparam int RF_AW = 5;
    localparam int TO = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       wb_src;
    logic [RF_AW-1:0] rd;
    logic [XLEN-1:0]  result;
    logic [XLEN-1:0]  csr_dataout;
    logic [XLEN-1:0]  pc;
    logic [1:0]       ld_size;
    logic             ld_unsigned;
    logic [2:0]       ld_off;
    logic             dmem_rvalid;
    logic [XLEN-1:0]  dmem_rdata;
    logic             rf_wen;
    logic [RF_AW-1:0] rf_waddr;
    logic [XLEN-1:0]  rf_wdata;
    logic             busy;
    logic [RF_AW-1:0] busy_rd;
    logic             load_err;

    int n_chk = 0;
    int n_fail = 0;

    wb_stage_mc #(.XLEN(XLEN), .RF_AW(RF_AW), .MEM_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .wb_src(wb_src), .rd(rd), .result(result), .csr_dataout(csr_dataout),
        .pc(pc), .ld_size(ld_size), .ld_unsigned(ld_unsigned), .ld_off(ld_off),
        .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata), .rf_wen(rf_wen),
        .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .busy(busy), .busy_rd(busy_rd),
        .load_err(load_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Load value from the arithmetic definition: pick the lane, reduce
    // modulo 2^w, and reinterpret as signed when requested.
    function automatic logic [31:0] ext_model(input logic [31:0] raw, input logic [1:0] sz,
                                              input logic uns, input logic [2:0] off);
        longint lane, w, v;
        lane = longint'(raw) >> (8 * (int'(off) % 4));
        w = (sz == 2'd0) ? 8 : (sz == 2'd1) ? 16 : 32;
        v = lane % (longint'(1) << w);
        if (!uns && v >= (longint'(1) << (w - 1)))
            v = v - (longint'(1) << w);
        return 32'(v);
    endfunction

    // Behavioural model state: one optional pending load and its age.
    bit               m_pending;
    int               m_wait;
    logic [RF_AW-1:0] m_rd;
    logic [1:0]       m_size;
    logic             m_uns;
    logic [2:0]       m_off;
    bit               m_wen;
    logic             e_wen;
    logic [RF_AW-1:0] e_waddr;
    logic [XLEN-1:0]  e_wdata;
    logic             e_err;

    always @(negedge clk) begin
        if (rst) begin
            m_pending = 0;
            m_wait    = 0;
            e_wen     = 0;
            e_waddr   = '0;
            e_wdata   = '0;
            e_err     = 0;
        end
        chk("m_rf_wen", rf_wen, e_wen);
        chk("m_rf_waddr", rf_waddr, e_waddr);
        chk("m_rf_wdata", rf_wdata, e_wdata);
        chk("m_load_err", load_err, e_err);
        chk("m_busy", busy, m_pending);
        chk("m_busy_rd", busy_rd, (m_pending && m_wen) ? m_rd : '0);
        chk("m_in_ready", in_ready, !m_pending);
        if (!rst) begin
            e_wen = 0;
            e_err = 0;
            if (!m_pending) begin
                if (in_valid) begin
                    if (wb_src[1:0] != 2'd0 || dmem_rvalid) begin
                        e_wen   = wb_src[2] && (rd != 0);
                        e_waddr = rd;
                        case (wb_src[1:0])
                            2'd0: e_wdata = ext_model(dmem_rdata, ld_size, ld_unsigned, ld_off);
                            2'd1: e_wdata = result;
                            2'd2: e_wdata = csr_dataout;
                            default: e_wdata = pc + 32'd4;
                        endcase
                    end else begin
                        m_pending = 1;
                        m_wait    = 0;
                        m_rd      = rd;
                        m_size    = ld_size;
                        m_uns     = ld_unsigned;
                        m_off     = ld_off;
                        m_wen     = wb_src[2] && (rd != 0);
                    end
                end
            end else begin
                m_wait++;
                if (dmem_rvalid) begin
                    e_wen     = m_wen;
                    e_waddr   = m_rd;
                    e_wdata   = ext_model(dmem_rdata, m_size, m_uns, m_off);
                    m_pending = 0;
                end else if (m_wait == TO) begin
                    e_err     = 1;
                    m_pending = 0;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] src, input logic [4:0] r,
                         input logic [1:0] sz, input logic u, input logic [2:0] off,
                         input logic rv, input logic [31:0] rdat);
        in_valid = v; wb_src = src; rd = r; ld_size = sz; ld_unsigned = u;
        ld_off = off; dmem_rvalid = rv; dmem_rdata = rdat;
    endtask

    initial begin
        rst = 1'b1;
        result = '0; csr_dataout = '0; pc = '0;
        drive(0, 3'b000, 0, 0, 0, 0, 0, 32'h0);

        // Pin the extension model on hand-computed values.
        chk("pin_sb", ext_model(32'h0080_0000, 2'd0, 1'b0, 3'd2), 32'hFFFF_FF80);
        chk("pin_ub", ext_model(32'h0080_0000, 2'd0, 1'b1, 3'd2), 32'h0000_0080);
        chk("pin_sh", ext_model(32'h8001_1234, 2'd1, 1'b0, 3'd2), 32'hFFFF_8001);
        chk("pin_off4", ext_model(32'h0000_00F0, 2'd0, 1'b0, 3'd4), 32'hFFFF_FFF0);

        repeat (3) step();
        chk("rst_ready", in_ready, 1'b1);
        chk("rst_wen", rf_wen, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_wdata", rf_wdata, 32'h0);
        rst = 1'b0;
        step();

        // ALU writeback
        result = 32'h1234;
        drive(1, 3'b101, 5, 0, 0, 0, 0, 32'h0);
        step();
        in_valid = 0;
        chk("alu_wen", rf_wen, 1'b1);
        chk("alu_waddr", rf_waddr, 5'd5);
        chk("alu_wdata", rf_wdata, 32'h1234);
        chk("alu_ready", in_ready, 1'b1);
        step();
        chk("alu_pulse", rf_wen, 1'b0);

        // x0 suppression
        result = 32'hFFFF;
        drive(1, 3'b101, 0, 0, 0, 0, 0, 32'h0);
        step();
        in_valid = 0;
        chk("x0_wen", rf_wen, 1'b0);
        step();
        chk("x0_wen2", rf_wen, 1'b0);

        // CSR and PC+4 with wrap
        csr_dataout = 32'hCAFE_F00D;
        drive(1, 3'b110, 2, 0, 0, 0, 0, 32'h0);
        step();
        chk("csr_wdata", rf_wdata, 32'hCAFE_F00D);
        pc = 32'hFFFF_FFFE;
        drive(1, 3'b111, 1, 0, 0, 0, 0, 32'h0);
        step();
        chk("pc4_wdata", rf_wdata, 32'h0000_0002);
        chk("pc4_waddr", rf_waddr, 5'd1);

        // Zero-latency byte loads
        drive(1, 3'b100, 4, 0, 0, 2, 1, 32'h0080_0000);
        step();
        chk("lb_wdata", rf_wdata, 32'hFFFF_FF80);
        chk("lb_wen", rf_wen, 1'b1);
        drive(1, 3'b100, 4, 0, 1, 2, 1, 32'h0080_0000);
        step();
        chk("lbu_wdata", rf_wdata, 32'h0000_0080);
        drive(0, 3'b000, 0, 0, 0, 0, 0, 32'h0);
        step();

        // Stalled word load
        drive(1, 3'b100, 7, 2, 0, 0, 0, 32'h0);
        step();
        in_valid = 0;
        chk("stall_busy", busy, 1'b1);
        chk("stall_busy_rd", busy_rd, 5'd7);
        chk("stall_ready", in_ready, 1'b0);
        step();
        step();
        dmem_rvalid = 1; dmem_rdata = 32'hDEAD_BEEF;
        step();
        dmem_rvalid = 0;
        chk("stall_wen", rf_wen, 1'b1);
        chk("stall_waddr", rf_waddr, 5'd7);
        chk("stall_wdata", rf_wdata, 32'hDEAD_BEEF);
        chk("stall_busy_done", busy, 1'b0);
        chk("stall_ready_done", in_ready, 1'b1);

        // Timeout
        drive(1, 3'b100, 9, 2, 0, 0, 0, 32'h0);
        step();
        in_valid = 0;
        repeat (3) step();
        chk("to_wait4_err", load_err, 1'b0);
        chk("to_wait4_busy", busy, 1'b1);
        step();
        chk("to_err", load_err, 1'b1);
        chk("to_wen", rf_wen, 1'b0);
        chk("to_ready", in_ready, 1'b1);
        step();
        chk("to_err_pulse", load_err, 1'b0);

        // rvalid in the timeout cycle wins
        drive(1, 3'b100, 10, 2, 0, 0, 0, 32'h0);
        step();
        in_valid = 0;
        repeat (3) step();
        dmem_rvalid = 1; dmem_rdata = 32'h1234_5678;
        step();
        dmem_rvalid = 0;
        chk("race_wen", rf_wen, 1'b1);
        chk("race_wdata", rf_wdata, 32'h1234_5678);
        chk("race_err", load_err, 1'b0);

        // Reset mid-wait
        drive(1, 3'b100, 3, 2, 0, 0, 0, 32'h0);
        step();
        in_valid = 0;
        chk("rw_busy", busy, 1'b1);
        rst = 1'b1;
        #1;
        chk("rw_busy_rst", busy, 1'b0);
        chk("rw_busy_rd_rst", busy_rd, 5'd0);
        chk("rw_ready_rst", in_ready, 1'b1);
        step();
        rst = 1'b0;
        dmem_rvalid = 1; dmem_rdata = 32'hAAAA_5555;
        step();
        dmem_rvalid = 0;
        chk("rw_late_wen", rf_wen, 1'b0);
        chk("rw_late_ready", in_ready, 1'b1);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            rst         = ($urandom_range(0, 399) == 0);
            in_valid    = ($urandom_range(0, 9) < 6);
            wb_src      = 3'($urandom);
            rd          = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            result      = $urandom;
            csr_dataout = $urandom;
            pc          = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : $urandom;
            ld_size     = 2'($urandom);
            ld_unsigned = 1'($urandom);
            ld_off      = 3'($urandom);
            dmem_rvalid = ($urandom_range(0, 9) < 3);
            dmem_rdata  = $urandom;
            step();
        end
        rst = 1'b0;
        drive(0, 3'b000, 0, 0, 0, 0, 0, 32'h0);
        repeat (8) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_stage_mc.md
Name: wb_stage_mc

Overview:
- Registered, parametrised writeback stage for the pipelined core. Selects the writeback source: data memory, ALU result, CSR read data, or PC+4.
- Aligns and sign/zero-extends sub-word loads.
- Absorbs variable-latency data-memory responses with a valid/ready stall handshake toward the upstream stage.
- Drives the register-file write port one cycle after acceptance, or after load-data return, and exports a busy/rd indication for hazard logic.

Parameters:
- XLEN, 32, datapath width (32 or 64)
- RF_AW, 5, register-file address width
- MEM_TIMEOUT, 255, max cycles waiting for dmem_rvalid before load_err; 0 disables the timeout

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  upstream instruction valid
- in_ready  out  1  stage can accept this cycle
- wb_src  in  3  bit2 = write enable; [1:0] = source: 0 DATAMEM, 1 RESULT, 2 CSR_DATAOUT, 3 PC4
- rd  in  RF_AW  destination register
- result  in  XLEN  ALU result
- csr_dataout  in  XLEN  CSR read data
- pc  in  XLEN  instruction PC
- ld_size  in  2  0 byte, 1 half, 2 word, 3 dword (XLEN=64 only)
- ld_unsigned  in  1  zero-extend when 1
- ld_off  in  3  byte offset of access within the XLEN word (bit2 ignored when XLEN=32)
- dmem_rvalid  in  1  load data valid
- dmem_rdata  in  XLEN  raw aligned-word load data
- rf_wen  out  1  register-file write enable
- rf_waddr  out  RF_AW  register-file write address
- rf_wdata  out  XLEN  register-file write data
- busy  out  1  a load is outstanding (state WAIT_MEM)
- busy_rd  out  RF_AW  rd of the outstanding load; 0 when not busy
- load_err  out  1  one-cycle pulse on timeout

Behaviour:
- Reset: state=IDLE, rf_wen=0, rf_waddr=0, rf_wdata=0, busy=0, busy_rd=0, load_err=0, timeout counter=0.
- Acceptance: an instruction is accepted when in_valid && in_ready. in_ready = (state==IDLE).
- Effective write enable: wb_src[2] && (rd!=0). Writes to x0 are always suppressed.
- Non-load accept (src 1/2/3): next cycle rf_wen=eff_wen, rf_waddr=rd, rf_wdata=source value. Latency 1. PC4 = pc+4, modulo 2^XLEN.
- Load accept (src 0) with dmem_rvalid in the same cycle: handled like a non-load, using extended data. Latency 1, no stall.
- Load accept without dmem_rvalid: go to WAIT_MEM.
  - Latch rd, ld_size, ld_unsigned, ld_off and eff_wen.
  - busy=1 and busy_rd=latched rd (busy_rd=0 if eff_wen=0).
  - in_ready=0.
- WAIT_MEM exit on dmem_rvalid:
  - The cycle after, rf_wen=latched eff_wen, with the extended data.
  - State returns to IDLE in the same edge, so in_ready=1 in the write cycle.
- Extension: lane = dmem_rdata >> (8*ld_off). Take the low 8/16/32/XLEN bits per ld_size, then sign- or zero-extend to XLEN.
  - ld_off is not checked for misalignment; upper bits beyond the word are discarded.
- Timeout: the counter increments each WAIT_MEM cycle without rvalid.
  - When it reaches MEM_TIMEOUT: load_err pulses for 1 cycle, no RF write, return to IDLE, counter clears.
  - dmem_rvalid arriving in the same cycle as the timeout wins: normal write, no error.
- dmem_rvalid in IDLE with no load accepted: ignored.
- rf_wen is a single-cycle pulse per retired instruction. Outputs are held when idle, but rf_wen=0.
- Async reset mid-WAIT_MEM: immediately IDLE, the pending write is discarded, busy=0.

Test Plan:
- ALU writeback: accept src=3'b101, rd=5, result=0x1234 -> next cycle rf_wen=1, waddr=5, wdata=0x1234; in_ready stays 1.
- x0 suppression: src=3'b101, rd=0, result=0xFFFF -> rf_wen stays 0 for all cycles.
- Sub-word load, zero latency:
  - src=3'b100, ld_size=0, ld_unsigned=0, ld_off=2, dmem_rvalid=1, rdata=0x0080_0000 -> wdata=0xFFFF_FF80 next cycle.
  - Same with ld_unsigned=1 -> 0x0000_0080.
- Stalled load:
  - Accept load rd=7 without rvalid -> busy=1, busy_rd=7, in_ready=0.
  - rvalid after 3 cycles with rdata=0xDEADBEEF, word size -> next cycle rf_wen=1, waddr=7, wdata=0xDEADBEEF, busy=0, in_ready=1.
- Timeout: MEM_TIMEOUT=4, load accepted, rvalid never arrives -> load_err pulses once on the 4th waiting cycle, no rf_wen, back to IDLE.
- Reset mid-wait: assert rst during WAIT_MEM -> busy=0, in_ready=1 after release, no write when a late rvalid arrives.
